instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//   Inverse of the immediate generator: packs decoded fields (format, opcode, regs, funct, signed imm)
//   into a 32-bit RV32I instruction word. Feeds test-program loaders and self-check benches writing
//   instruction memory. Checks immediate range/alignment per format, buffers words in a small FIFO,
//   and uses valid/ready handshakes on both sides.
// PARAMETERS
//   XLEN        32  width of in_imm (signed two's complement)
//   FIFO_DEPTH  4   output FIFO entries; power of 2, >=2
//   CNT_W       16  width of the enc_count/err_count statistics counters
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      reset, asynchronous, active-low
//   in_valid   in   1      request valid
//   in_ready   out  1      request accepted when in_valid&in_ready at rising edge
//   in_fmt     in   3      R=0 I=1 S=2 B=3 U=4 J=5; 6,7 illegal
//   in_opcode  in   7      copied raw to instr[6:0]
//   in_rd      in   5      instr[11:7] (R/I/U/J)
//   in_rs1     in   5      instr[19:15] (R/I/S/B)
//   in_rs2     in   5      instr[24:20] (R/S/B)
//   in_funct3  in   3      instr[14:12] (R/I/S/B)
//   in_funct7  in   7      instr[31:25] (R only)
//   in_imm     in   XLEN   signed immediate, byte offset for B/J, full value for U
//   out_valid  out  1      FIFO head valid
//   out_ready  in   1      consumer accepts head when out_valid&out_ready
//   out_instr  out  32     encoded word at FIFO head
//   out_err    out  1      head word was rejected (out_instr = 32'h0000_0013 NOP)
//   enc_count  out  CNT_W  words pushed without error, saturating
//   err_count  out  CNT_W  words pushed with error, saturating
// BEHAVIOUR
//   Reset (async, rst_n=0): FIFO emptied, out_valid=0, out_instr=0, out_err=0, counters=0; in_ready=1.
//   in_ready = !full. A push while full is not allowed, even with a same-cycle pop.
//   Encoding is combinational on inputs; the result is written to FIFO on accept.
//   Latency: word accepted at edge N has out_valid=1 after edge N when FIFO was empty.
//   Field packing by format (imm = in_imm):
//     R: {funct7,rs2,rs1,funct3,rd,opcode}; in_imm ignored, never errors
//     I: {imm[11:0],rs1,funct3,rd,opcode}
//     S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}
//     B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}
//     U: {imm[31:12],rd,opcode}
//     J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}
//   Error checks (any failure -> word 32'h0000_0013, err bit=1):
//     I/S: imm outside [-2048,2047]; B: outside [-4096,4094] or imm[0]=1
//     J: outside [-2^20,2^20-2] or imm[0]=1; U: imm[11:0]!=0 (and, if XLEN>32, imm outside signed 32b)
//     in_fmt>=6.
//   FIFO: FIFO_DEPTH entries of {err,instr}; ptrs wrap mod depth; count width log2(DEPTH)+1.
//     Simultaneous push+pop when not full and not empty: occupancy unchanged, order preserved.
//     Pop when empty is ignored.
//   out_instr/out_err show the head entry, or hold the last popped value while empty (0 after reset).
//   Counters: +1 per accepted push; increment enc_count or err_count by err bit; saturate at all-ones.
//   Reset mid-stream: queued words are discarded without being presented; any in-flight accept is lost.
// TESTING
//   1 I: fmt=1 opc=0x13 rd=1 rs1=0 f3=0 imm=-1 -> out_instr=0xFFF00093, err=0, valid 1 cycle after accept
//   2 B: fmt=3 opc=0x63 rs1=1 rs2=2 f3=0 imm=8 -> 0x00208463; S: fmt=2 opc=0x23 rs1=1 rs2=2 f3=2 imm=-2048 -> 0x8020A023
//   3 U: fmt=4 opc=0x37 rd=5 imm=0x12345000 -> 0x123452B7; imm=0x12345001 -> 0x00000013 err=1, err_count=1
//   4 Errors: J imm=3, S imm=2048, fmt=6 -> three NOPs, err=1; enc_count unchanged, err_count +3
//   5 Backpressure: out_ready=0, offer 5 words -> in_ready=0 after 4th; release -> 5 words in order, none lost
//   6 Reset with 3 words queued -> out_valid=0 immediately (async), counters=0, in_ready=1; next word flows normally

Source files
------------

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - request/response bundle for the RV32I instruction encoder
//
// Purpose: groups the encoder's request handshake (decoded fields in) and its
// response handshake (encoded word out) so producer and consumer share one port.
// Ports (signals):
//   in_valid/in_ready        request handshake
//   in_fmt/in_opcode/in_rd/in_rs1/in_rs2/in_funct3/in_funct7/in_imm  decoded fields
//   out_valid/out_ready      response handshake
//   out_instr/out_err        FIFO head word and its reject flag
// Modports: master drives requests and consumes words; slave is the encoder.
interface instr_encoder_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_fmt;
  logic [6:0]      in_opcode;
  logic [4:0]      in_rd;
  logic [4:0]      in_rs1;
  logic [4:0]      in_rs2;
  logic [2:0]      in_funct3;
  logic [6:0]      in_funct7;
  logic [XLEN-1:0] in_imm;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic            out_err;

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  out_ready,
    output in_ready, out_valid, out_instr, out_err
  );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs decoded fields into RV32I words through a small output FIFO
//
// Purpose: encodes R/I/S/B/U/J requests into 32-bit instructions, replacing any
// request with an out-of-range or misaligned immediate (or illegal format) by a
// NOP flagged with out_err, and queues the results for a downstream consumer.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        instr_encoder_if.slave: request fields in, encoded word out
//   enc_count  saturating count of words queued without error
//   err_count  saturating count of words queued with error
module instr_encoder #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  instr_encoder_if.slave   bus,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic signed [XLEN-1:0] I_MIN = XLEN'(-64'sd2048);
  localparam logic signed [XLEN-1:0] I_MAX = XLEN'(64'sd2047);
  localparam logic signed [XLEN-1:0] B_MIN = XLEN'(-64'sd4096);
  localparam logic signed [XLEN-1:0] B_MAX = XLEN'(64'sd4094);
  localparam logic signed [XLEN-1:0] J_MIN = XLEN'(-64'sd1048576);
  localparam logic signed [XLEN-1:0] J_MAX = XLEN'(64'sd1048574);
  // Only meaningful when XLEN > 32; at XLEN = 32 every value is inside.
  localparam logic signed [XLEN-1:0] U_MIN = XLEN'(-64'sd2147483648);
  localparam logic signed [XLEN-1:0] U_MAX = XLEN'(64'sd2147483647);

  typedef struct packed {
    logic        err;
    logic [31:0] instr;
  } entry_t;

  entry_t          mem_q [FIFO_DEPTH];
  entry_t          mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     cnt_q, cnt_d;
  entry_t          hold_q, hold_d;
  logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic                   full, empty, push, pop;
  logic signed [XLEN-1:0] imm_s;
  logic [XLEN-1:0]        imm;
  logic [31:0]            enc_word;
  logic                   enc_err;
  entry_t                 head;

  assign imm   = bus.in_imm;
  assign imm_s = $signed(bus.in_imm);

  // Combinational encoder: the word is formed from the live inputs and only
  // captured into the FIFO on an accepted push.
  always_comb begin
    enc_word = NOP;
    enc_err  = 1'b0;
    case (bus.in_fmt)
      3'd0: enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
      3'd1: begin
        enc_err  = (imm_s < I_MIN) || (imm_s > I_MAX);
        enc_word = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
      end
      3'd2: begin
        enc_err  = (imm_s < I_MIN) || (imm_s > I_MAX);
        enc_word = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], bus.in_opcode};
      end
      3'd3: begin
        enc_err  = (imm_s < B_MIN) || (imm_s > B_MAX) || imm[0];
        enc_word = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                    imm[4:1], imm[11], bus.in_opcode};
      end
      3'd4: begin
        enc_err  = (imm[11:0] != 12'd0) || ((XLEN > 32) && ((imm_s < U_MIN) || (imm_s > U_MAX)));
        enc_word = {imm[31:12], bus.in_rd, bus.in_opcode};
      end
      3'd5: begin
        enc_err  = (imm_s < J_MIN) || (imm_s > J_MAX) || imm[0];
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
      end
      default: enc_err = 1'b1;
    endcase
    if (enc_err) begin
      enc_word = NOP;
    end
  end

  assign full  = (cnt_q == DEPTH_C);
  assign empty = (cnt_q == '0);
  // Push is gated only by full: a pop in the same cycle does not free a slot early.
  assign push  = bus.in_valid && !full;
  assign pop   = bus.out_ready && !empty;

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    enc_cnt_d = enc_cnt_q;
    err_cnt_d = err_cnt_q;

    if (push) begin
      mem_d[wr_ptr_q] = '{err: enc_err, instr: enc_word};
      wr_ptr_d        = wr_ptr_q + AW'(1);
      if (enc_err) begin
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
      end else begin
        if (enc_cnt_q != '1) enc_cnt_d = enc_cnt_q + CNT_W'(1);
      end
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      // Remember what left so the outputs keep showing it once the FIFO drains.
      hold_d   = mem_q[rd_ptr_q];
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      hold_q    <= '0;
      enc_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      enc_cnt_q <= enc_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign head          = empty ? hold_q : mem_q[rd_ptr_q];
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_instr = head.instr;
  assign bus.out_err   = head.err;
  assign enc_count     = enc_cnt_q;
  assign err_count     = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder
module tb_instr_encoder;

  logic        clk;
  logic        rst_n;
  logic [15:0] enc_count;
  logic [15:0] err_count;

  instr_encoder_if bus ();

  instr_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  bit [32:0] exp_q[$];
  bit [32:0] exp_hold = '0;
  int        exp_enc  = 0;
  int        exp_err  = 0;
  int        pop_cnt  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference encoder: plain shift/mask arithmetic on the field table.
  function automatic bit [32:0] ref_enc(input int unsigned fmt, input int unsigned opc,
                                        input int unsigned rd, input int unsigned rs1,
                                        input int unsigned rs2, input int unsigned f3,
                                        input int unsigned f7, input int imm);
    bit [31:0] u;
    bit [31:0] w;
    bit        bad;
    u   = imm;
    bad = 0;
    w   = 0;
    case (fmt)
      0: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
      1: begin
        bad = (imm < -2048) || (imm > 2047);
        w = ((u & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
      end
      2: begin
        bad = (imm < -2048) || (imm > 2047);
        w = (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
            | ((u & 32'h1F) << 7) | opc;
      end
      3: begin
        bad = (imm < -4096) || (imm > 4094) || ((imm & 1) != 0);
        w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (rs2 << 20) | (rs1 << 15)
            | (f3 << 12) | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | opc;
      end
      4: begin
        bad = (u & 32'hFFF) != 0;
        w = (u & 32'hFFFF_F000) | (rd << 7) | opc;
      end
      5: begin
        bad = (imm < -1048576) || (imm > 1048574) || ((imm & 1) != 0);
        w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) | (((u >> 11) & 1) << 20)
            | (((u >> 12) & 32'hFF) << 12) | (rd << 7) | opc;
      end
      default: bad = 1;
    endcase
    if (bad) w = 32'h0000_0013;
    return {bad, w};
  endfunction

  // One clock: predict accept/pop from the settled signals, advance, then audit status.
  task automatic cycle();
    bit        acc;
    bit        pp;
    bit [32:0] e;
    bit [32:0] h;
    acc = bus.in_valid && bus.in_ready;
    pp  = bus.out_valid && bus.out_ready;
    if (pp) begin
      if (exp_q.size() == 0) begin
        check("pop_on_empty_model", 1, 0);
      end else begin
        h = exp_q.pop_front();
        check("pop_instr", bus.out_instr, h[31:0]);
        check("pop_err", bus.out_err, h[32]);
        exp_hold = h;
        pop_cnt++;
      end
    end
    if (acc) begin
      e = ref_enc(bus.in_fmt, bus.in_opcode, bus.in_rd, bus.in_rs1, bus.in_rs2,
                  bus.in_funct3, bus.in_funct7, $signed(bus.in_imm));
      exp_q.push_back(e);
      if (e[32]) begin
        if (exp_err < 65535) exp_err++;
      end else begin
        if (exp_enc < 65535) exp_enc++;
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", bus.out_valid, exp_q.size() != 0);
    check("in_ready", bus.in_ready, exp_q.size() < 4);
    check("enc_count", enc_count, exp_enc);
    check("err_count", err_count, exp_err);
    if (exp_q.size() == 0) begin
      check("hold_instr", bus.out_instr, exp_hold[31:0]);
      check("hold_err", bus.out_err, exp_hold[32]);
    end
  endtask

  task automatic drive(input int fmt, input int opc, input int rd, input int rs1,
                       input int rs2, input int f3, input int f7, input int imm);
    bus.in_fmt    = 3'(fmt);
    bus.in_opcode = 7'(opc);
    bus.in_rd     = 5'(rd);
    bus.in_rs1    = 5'(rs1);
    bus.in_rs2    = 5'(rs2);
    bus.in_funct3 = 3'(f3);
    bus.in_funct7 = 7'(f7);
    bus.in_imm    = imm;
  endtask

  // Offer the driven request into an empty FIFO, check the head against a literal, then drain it.
  task automatic offer_and_pop(input string tag, input logic [31:0] exp_w, input logic exp_e);
    bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    check({tag, "_valid"}, bus.out_valid, 1);
    check({tag, "_instr"}, bus.out_instr, exp_w);
    check({tag, "_err"}, bus.out_err, exp_e);
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
  endtask

  function automatic int rand_imm();
    int edges[14];
    edges = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, -4098,
              1048574, -1048576, 1048576, -1048578, 0, -1};
    case ($urandom_range(0, 5))
      0: return $urandom_range(0, 10000) - 5000;
      1: return edges[$urandom_range(0, 13)];
      2: return $urandom;
      3: return int'($urandom) & 32'hFFFF_F000;
      4: return ($urandom_range(0, 2097151) - 1048576) & ~1;
      default: return ($urandom_range(0, 9000) - 4500) & ~1;
    endcase
  endfunction

  initial begin
    int guard;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_instr", bus.out_instr, 0);
    check("rst_out_err", bus.out_err, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_enc_count", enc_count, 0);
    check("rst_err_count", err_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: I-type, one-cycle latency
    drive(1, 'h13, 1, 0, 0, 0, 0, -1);
    offer_and_pop("t1", 32'hFFF0_0093, 0);

    // 2: B and S
    drive(3, 'h63, 0, 1, 2, 0, 0, 8);
    offer_and_pop("t2b", 32'h0020_8463, 0);
    drive(2, 'h23, 0, 1, 2, 2, 0, -2048);
    offer_and_pop("t2s", 32'h8020_A023, 0);

    // 3: U legal and misaligned
    drive(4, 'h37, 5, 0, 0, 0, 0, 'h1234_5000);
    offer_and_pop("t3u", 32'h1234_52B7, 0);
    drive(4, 'h37, 5, 0, 0, 0, 0, 'h1234_5001);
    offer_and_pop("t3bad", 32'h0000_0013, 1);
    check("t3_err_count", err_count, 1);
    check("t3_enc_count", enc_count, 4);

    // 4: assorted errors
    drive(5, 'h6F, 1, 0, 0, 0, 0, 3);
    offer_and_pop("t4j", 32'h0000_0013, 1);
    drive(2, 'h23, 0, 1, 2, 2, 0, 2048);
    offer_and_pop("t4s", 32'h0000_0013, 1);
    drive(6, 'h33, 1, 2, 3, 0, 0, 0);
    offer_and_pop("t4fmt", 32'h0000_0013, 1);
    check("t4_err_count", err_count, 4);
    check("t4_enc_count", enc_count, 4);

    // 5: backpressure with 5 words against a 4-deep FIFO
    pop_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 'h13, i + 1, i, 0, 0, 0, i * 100);
      bus.in_valid = 1'b1;
      cycle();
    end
    check("t5_full_ready", bus.in_ready, 0);
    drive(0, 'h33, 9, 8, 7, 1, 'h20, 0);
    cycle();
    cycle();
    check("t5_still_full", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 20) begin
      cycle();
      guard++;
    end
    cycle();
    bus.in_valid = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      cycle();
      guard++;
    end
    check("t5_drained", exp_q.size(), 0);
    check("t5_pops", pop_cnt, 5);
    bus.out_ready = 1'b0;

    // 6: asynchronous reset with three words queued
    for (int i = 0; i < 3; i++) begin
      drive(4, 'h17, i, 0, 0, 0, 0, (i + 1) << 12);
      bus.in_valid = 1'b1;
      cycle();
    end
    bus.in_valid = 1'b0;
    check("t6_queued", bus.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_out_valid", bus.out_valid, 0);
    check("t6_in_ready", bus.in_ready, 1);
    check("t6_enc_count", enc_count, 0);
    check("t6_err_count", err_count, 0);
    check("t6_out_instr", bus.out_instr, 0);
    exp_q.delete();
    exp_enc  = 0;
    exp_err  = 0;
    exp_hold = '0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1, 'h13, 1, 0, 0, 0, 0, -1);
    offer_and_pop("t6_next", 32'hFFF0_0093, 0);
    check("t6_next_count", enc_count, 1);

    // Randomized traffic against the reference model
    for (int n = 0; n < 2000; n++) begin
      drive($urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, 31),
            $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 7),
            $urandom_range(0, 127), rand_imm());
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      cycle();
      guard++;
    end
    check("final_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
